serial_compare: RTL and testbench

Bit-serial magnitude comparator: the serial-input counterpart of the team's parallel 4-bit less-than/greater/equal/max comparators. It receives two WIDTH-bit operands MSB-first, one bit pair per accepted cycle. It produces registered lt/gt/eq flags plus the max and min operand. It sits behind a serial link or shift-out source and feeds the ALU result mux.

---
 rtl/serial_cmp_pkg.sv | 17 +
 rtl/serial_cmp_fsm.sv | 75 +++++++
 rtl/serial_compare.sv | 102 ++++++++++
 tb/tb_serial_compare.sv | 136 +++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared state encoding and sizing helper for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_cmp_fsm.sv
// Sequencer for serial_compare: state register, bit counter, busy/done and the strobes
// that drive the datapath. SERIAL_CMP_SIGNED_EN adds the 'first' (MSB pair) indication.
module serial_cmp_fsm
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  output logic busy,
  output logic done,
  output logic clear,
  output logic accept,
`ifdef SERIAL_CMP_SIGNED_EN
  output logic first,
`endif
  output logic load
);

  localparam int CW = clog2(WIDTH + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // The counter only advances on accepted pairs, so a stall leaves everything frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = (state == ST_SHIFT);
    done      = (state == ST_DONE);
    accept    = (state == ST_SHIFT) && bit_valid;
    clear     = start && ((state == ST_IDLE) || (state == ST_DONE));
    load      = accept && (cnt == CW'(WIDTH - 1));
`ifdef SERIAL_CMP_SIGNED_EN
    first     = (cnt == '0);
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_valid) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nxt = ST_DONE;
        end
      end
      // DONE can restart directly so back-to-back compares lose no cycle.
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/serial_compare.sv
// Bit-serial MSB-first magnitude comparator with registered lt/gt/eq and max/min operands.
// Define SERIAL_CMP_SIGNED_EN to compare two's-complement operands instead of unsigned.
module serial_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             x_bit,
  input  logic             y_bit,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o
);

  logic             clear, accept, load;
  logic [WIDTH-1:0] x_sr, y_sr, x_sh, y_sh;
  logic             decided, x_wins, y_wins;
  logic             x_beats, y_beats;
  logic             decided_nxt, x_wins_nxt, y_wins_nxt;
`ifdef SERIAL_CMP_SIGNED_EN
  logic             first;
`endif

  serial_cmp_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .clear     (clear),
    .accept    (accept),
`ifdef SERIAL_CMP_SIGNED_EN
    .first     (first),
`endif
    .load      (load)
  );

  // The first differing pair decides; the final pair is folded in combinationally
  // so the result registers can load on the same edge that accepts it.
  always_comb begin
    x_sh    = {x_sr[WIDTH-2:0], x_bit};
    y_sh    = {y_sr[WIDTH-2:0], y_bit};
`ifdef SERIAL_CMP_SIGNED_EN
    // A set sign bit means negative, so the MSB pair votes the other way.
    x_beats = first ? (~x_bit & y_bit) : (x_bit & ~y_bit);
    y_beats = first ? (x_bit & ~y_bit) : (~x_bit & y_bit);
`else
    x_beats = x_bit & ~y_bit;
    y_beats = ~x_bit & y_bit;
`endif
    x_wins_nxt  = x_wins | (~decided & x_beats);
    y_wins_nxt  = y_wins | (~decided & y_beats);
    decided_nxt = decided | x_beats | y_beats;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sr    <= '0;
      y_sr    <= '0;
      decided <= 1'b0;
      x_wins  <= 1'b0;
      y_wins  <= 1'b0;
    end else if (clear) begin
      decided <= 1'b0;
      x_wins  <= 1'b0;
      y_wins  <= 1'b0;
    end else if (accept) begin
      x_sr    <= x_sh;
      y_sr    <= y_sh;
      decided <= decided_nxt;
      x_wins  <= x_wins_nxt;
      y_wins  <= y_wins_nxt;
    end
  end

  // Results persist across new compares and only change when the next one completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      max_o <= '0;
      min_o <= '0;
    end else if (load) begin
      gt    <= x_wins_nxt;
      lt    <= y_wins_nxt;
      eq    <= ~(x_wins_nxt | y_wins_nxt);
      max_o <= y_wins_nxt ? y_sh : x_sh;
      min_o <= y_wins_nxt ? x_sh : y_sh;
    end
  end

endmodule

// File: tb/tb_serial_compare.sv
// Directed self-checking bench for serial_compare (WIDTH=4); expectations follow
// SERIAL_CMP_SIGNED_EN so the same bench covers both builds.
module tb_serial_compare;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, bit_valid = 1'b0, x_bit = 1'b0, y_bit = 1'b0;
  logic       busy, done, lt, gt, eq;
  logic [3:0] max_o, min_o;
  int         passCount = 0;
  int         totalCount = 0;

  serial_compare #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .x_bit(x_bit), .y_bit(y_bit), .busy(busy), .done(done),
    .lt(lt), .gt(gt), .eq(eq), .max_o(max_o), .min_o(min_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, then move to the next falling edge where outputs are stable.
  task automatic applyStimulus(input logic s, input logic v, input logic xb, input logic yb);
    start = s; bit_valid = v; x_bit = xb; y_bit = yb;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic checkResult(input string tag, input logic l, input logic g, input logic e,
                             input logic [3:0] mx, input logic [3:0] mn);
    checkOutput({tag, ".done"}, 16'(done), 16'(1'b1));
    checkOutput({tag, ".busy"}, 16'(busy), 16'(1'b0));
    checkOutput({tag, ".lt"}, 16'(lt), 16'(l));
    checkOutput({tag, ".gt"}, 16'(gt), 16'(g));
    checkOutput({tag, ".eq"}, 16'(eq), 16'(e));
    checkOutput({tag, ".max"}, 16'(max_o), 16'(mx));
    checkOutput({tag, ".min"}, 16'(min_o), 16'(mn));
  endtask

  task automatic shiftBits(input logic [3:0] xv, input logic [3:0] yv, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) applyStimulus(1'b0, 1'b1, xv[i], yv[i]);
  endtask

  initial begin
    @(negedge clk);
    checkOutput("reset.busy", 16'(busy), 16'd0);
    checkOutput("reset.done", 16'(done), 16'd0);
    checkOutput("reset.flags", 16'({lt, gt, eq}), 16'd0);
    checkOutput("reset.max", 16'(max_o), 16'd0);
    checkOutput("reset.min", 16'(min_o), 16'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // X=1010 Y=0110: done must appear only after the fourth pair
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1.busy", 16'(busy), 16'd1);
    shiftBits(4'b1010, 4'b0110, 3, 1);
    checkOutput("t1.early_done", 16'(done), 16'd0);
    checkOutput("t1.no_flags_yet", 16'({lt, gt, eq}), 16'd0);
    shiftBits(4'b1010, 4'b0110, 0, 0);
    checkResult("t1", SIGNED_BUILD, !SIGNED_BUILD, 1'b0,
                SIGNED_BUILD ? 4'b0110 : 4'b1010, SIGNED_BUILD ? 4'b1010 : 4'b0110);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1.idle_done", 16'(done), 16'd0);
    checkOutput("t1.idle_busy", 16'(busy), 16'd0);
    checkOutput("t1.hold_gt", 16'(gt), 16'(!SIGNED_BUILD));

    // Equal operands
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    shiftBits(4'b0011, 4'b0011, 3, 0);
    checkResult("t2", 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0011);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // X=0100 Y=0101 with a three-cycle stall after the second pair; junk bits while stalled
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    shiftBits(4'b0100, 4'b0101, 3, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t3.stall_busy", 16'(busy), 16'd1);
      checkOutput("t3.stall_done", 16'(done), 16'd0);
    end
    shiftBits(4'b0100, 4'b0101, 1, 0);
    checkResult("t3", 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // start during SHIFT is ignored: X=1100 Y=1100 still completes on time
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    shiftBits(4'b1100, 4'b1100, 3, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t4.start_ignored_busy", 16'(busy), 16'd1);
    shiftBits(4'b1100, 4'b1100, 1, 0);
    checkResult("t4a", 1'b0, 1'b0, 1'b1, 4'b1100, 4'b1100);
    // start in the DONE cycle goes straight back to SHIFT
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t4.b2b_busy", 16'(busy), 16'd1);
    checkOutput("t4.b2b_hold_eq", 16'(eq), 16'd1);
    shiftBits(4'b1111, 4'b0000, 3, 0);
    checkResult("t4b", SIGNED_BUILD, !SIGNED_BUILD, 1'b0,
                SIGNED_BUILD ? 4'b0000 : 4'b1111, SIGNED_BUILD ? 4'b1111 : 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle after two pairs
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    shiftBits(4'b1010, 4'b0101, 3, 2);
    start = 1'b0; bit_valid = 1'b1; x_bit = 1'b1; y_bit = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("t5.rst_busy", 16'(busy), 16'd0);
    checkOutput("t5.rst_flags", 16'({lt, gt, eq}), 16'd0);
    checkOutput("t5.rst_max", 16'(max_o), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5.no_done", 16'(done), 16'd0);
    checkOutput("t5.idle", 16'(busy), 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    shiftBits(4'b0001, 4'b1000, 3, 0);
    checkResult("t5", !SIGNED_BUILD, SIGNED_BUILD, 1'b0,
                SIGNED_BUILD ? 4'b0001 : 4'b1000, SIGNED_BUILD ? 4'b1000 : 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
